softusb_hostmbox: RTL

Host-side control and mailbox block for the softusb coprocessor, a parametrised successor to the single-event host interface. It holds the coprocessor in reset under CSR control and exposes its debug program counter. It takes `nirq` maskable event channels and a byte FIFO, both written by the coprocessor I/O bus, and raises a level IRQ toward the CPU. Everything runs on `sys_clk`, with no clock-domain crossing inside the block.

---
 rtl/softusb_hostmbox.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/softusb_hostmbox.sv
// softusb_hostmbox
// Host-side control and mailbox block for the softusb coprocessor.
// Holds the coprocessor in reset under CSR control, exposes its debug PC,
// collects nirq maskable event channels and a byte mailbox FIFO written by
// the coprocessor I/O bus, and raises a level interrupt toward the CPU.
//
// Ports:
//   sys_clk    - single clock for the whole block
//   sys_rst_n  - asynchronous active-low reset
//   csr_a      - CSR address; [13:10] bank select, [2:0] register index
//   csr_we     - CSR write strobe
//   csr_di     - CSR write data
//   csr_do     - registered CSR read data (0 when bank not selected)
//   irq        - registered level interrupt
//   usb_rst    - coprocessor reset, active-high
//   io_we      - coprocessor I/O write strobe
//   io_a       - coprocessor I/O address (0x15/0x17 events, 0x16 FIFO push)
//   io_do      - coprocessor I/O write data
//   dbg_pc     - coprocessor program counter
module softusb_hostmbox #(
    parameter logic [3:0] csr_addr        = 4'h0,
    parameter int         pmem_width      = 12,
    parameter int         nirq            = 4,
    parameter int         fifo_depth_log2 = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [13:0]           csr_a,
    input  logic                  csr_we,
    input  logic [31:0]           csr_di,
    output logic [31:0]           csr_do,
    output logic                  irq,
    output logic                  usb_rst,
    input  logic                  io_we,
    input  logic [5:0]            io_a,
    input  logic [7:0]            io_do,
    input  logic [pmem_width-1:0] dbg_pc
);

    localparam int depth_c = 1 << fifo_depth_log2;

    typedef logic [fifo_depth_log2-1:0] ptr_t;
    typedef logic [fifo_depth_log2:0]   lvl_t;

    localparam lvl_t full_level_c = lvl_t'(depth_c);
    localparam lvl_t zero_level_c = lvl_t'(0);

    // State registers
    logic                usb_rst_r;
    logic                fifo_ie_r;
    logic [nirq-1:0]     pending_r;
    logic [nirq-1:0]     mask_r;
    logic                ovf_r;
    ptr_t                wr_ptr_r;
    ptr_t                rd_ptr_r;
    lvl_t                level_r;
    logic [7:0]          mem_r [depth_c];
    logic [31:0]         csr_do_r;
    logic                irq_r;

    // Decode and datapath signals
    logic                bank_sel_s;
    logic                csr_wr_s;
    logic [2:0]          reg_idx_s;
    logic                io_en_s;
    logic [15:0]         set16_s;
    logic [nirq-1:0]     pend_set_s;
    logic [nirq-1:0]     pend_clr_s;
    logic                empty_s;
    logic                full_s;
    logic                flush_s;
    logic                push_req_s;
    logic                pop_req_s;
    logic                do_push_s;
    logic                do_pop_s;
    logic                ovf_set_s;
    logic                ovf_clr_s;
    logic [7:0]          head_s;
    logic [31:0]         rd_data_s;
    logic                irq_next_s;
    logic                unused_s;

    assign bank_sel_s = (csr_a[13:10] == csr_addr);
    assign csr_wr_s   = bank_sel_s & csr_we;
    assign reg_idx_s  = csr_a[2:0];
    // Coprocessor I/O writes are ignored while the coprocessor is held in reset.
    assign io_en_s    = io_we & ~usb_rst_r;

    assign empty_s    = (level_r == zero_level_c);
    assign full_s     = (level_r == full_level_c);
    assign flush_s    = csr_wr_s & (reg_idx_s == 3'd0) & csr_di[2];
    assign push_req_s = io_en_s & (io_a == 6'h16);
    assign pop_req_s  = csr_wr_s & (reg_idx_s == 3'd4);
    assign ovf_clr_s  = csr_wr_s & (reg_idx_s == 3'd5) & csr_di[16];
    assign head_s     = empty_s ? 8'h00 : mem_r[rd_ptr_r];

    assign irq_next_s = (|(pending_r & mask_r)) | (fifo_ie_r & ~empty_s);

    assign csr_do  = csr_do_r;
    assign irq     = irq_r;
    assign usb_rst = usb_rst_r;

    // Address bits and data bits that no register consumes.
    assign unused_s = ^{csr_a[9:3], csr_di, set16_s};

    // Event set/clear vectors: io 0x15 feeds channels 7:0, io 0x17 feeds 15:8,
    // then the 16-bit view is truncated to the configured channel count.
    always_comb begin
        set16_s = 16'h0000;
        if (io_en_s && (io_a == 6'h15)) begin
            set16_s[7:0] = io_do;
        end else begin
            set16_s[7:0] = 8'h00;
        end
        if (io_en_s && (io_a == 6'h17)) begin
            set16_s[15:8] = io_do;
        end else begin
            set16_s[15:8] = 8'h00;
        end
        pend_set_s = set16_s[nirq-1:0];
        if (csr_wr_s && (reg_idx_s == 3'd2)) begin
            pend_clr_s = csr_di[nirq-1:0];
        end else begin
            pend_clr_s = {nirq{1'b0}};
        end
    end

    // FIFO push/pop arbitration. A pop frees a slot so a push into a full FIFO
    // in the same cycle is accepted; flush overrides both and never flags ovf.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        ovf_set_s = 1'b0;
        if (flush_s) begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
            ovf_set_s = 1'b0;
        end else begin
            do_pop_s  = pop_req_s & ~empty_s;
            do_push_s = push_req_s & (~full_s | do_pop_s);
            ovf_set_s = push_req_s & full_s & ~do_pop_s;
        end
    end

    // CSR read mux, sampled from the current address and current state.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (bank_sel_s) begin
            case (reg_idx_s)
                3'd0:    rd_data_s[1:0] = {fifo_ie_r, usb_rst_r};
                3'd1:    rd_data_s[pmem_width:1] = dbg_pc;
                3'd2:    rd_data_s[nirq-1:0] = pending_r;
                3'd3:    rd_data_s[nirq-1:0] = mask_r;
                3'd4:    rd_data_s[8:0] = {~empty_s, head_s};
                3'd5: begin
                    rd_data_s[16]                = ovf_r;
                    rd_data_s[fifo_depth_log2:0] = level_r;
                end
                default: rd_data_s = 32'h0000_0000;
            endcase
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // Control, event and overflow registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            usb_rst_r <= 1'b1;
            fifo_ie_r <= 1'b0;
            pending_r <= {nirq{1'b0}};
            mask_r    <= {nirq{1'b0}};
            ovf_r     <= 1'b0;
        end else begin
            if (csr_wr_s && (reg_idx_s == 3'd0)) begin
                usb_rst_r <= csr_di[0];
                fifo_ie_r <= csr_di[1];
            end else begin
                usb_rst_r <= usb_rst_r;
                fifo_ie_r <= fifo_ie_r;
            end
            if (csr_wr_s && (reg_idx_s == 3'd3)) begin
                mask_r <= csr_di[nirq-1:0];
            end else begin
                mask_r <= mask_r;
            end
            // Set is ORed in after the clear so a colliding set wins.
            pending_r <= (pending_r & ~pend_clr_s) | pend_set_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_r <= ptr_t'(0);
            rd_ptr_r <= ptr_t'(0);
            level_r  <= zero_level_c;
        end else if (flush_s) begin
            wr_ptr_r <= ptr_t'(0);
            rd_ptr_r <= ptr_t'(0);
            level_r  <= zero_level_c;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_t'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_t'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + lvl_t'(1);
                2'b01:   level_r <= level_r - lvl_t'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Mailbox storage; contents are only meaningful below the fill level, so no reset.
    always_ff @(posedge sys_clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= io_do;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Registered outputs: read data and interrupt level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csr_do_r <= 32'h0000_0000;
            irq_r    <= 1'b0;
        end else begin
            csr_do_r <= rd_data_s;
            irq_r    <= irq_next_s;
        end
    end

endmodule
